mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single backing-memory port between I-side and D-side cache-line refills/writebacks.
//  Sits below fetch and memory stages; their miss flags (fetch/memory miss) hold while a request is pending.
//  Grants one requester at a time, runs a LINE_WORDS-beat burst, then pulses done so the stall releases.
// PARAMETERS
//  XLEN        32  data/address width (taken from isa package)
//  LINE_WORDS  4   beats per burst; power of two, >=2
// PORTS
//  clk        in   1     clock
//  rst        in   1     reset: synchronous, active-high
//  i_req      in   1     I-side refill request; held until i_done
//  i_addr     in   XLEN  I-side line base address (line-aligned)
//  i_rvalid   out  1     I-side beat data valid
//  i_rdata    out  XLEN  I-side beat data
//  i_done     out  1     one-cycle pulse: I burst finished
//  d_req      in   1     D-side request; held until d_done
//  d_we       in   1     D-side burst is writeback (1) or refill (0)
//  d_addr     in   XLEN  D-side line base address (line-aligned)
//  d_wdata    in   XLEN  D-side write beat, indexed by d_beat
//  d_beat     out  $clog2(LINE_WORDS)  current beat index for D-side write data
//  d_rvalid   out  1     D-side read beat data valid
//  d_rdata    out  XLEN  D-side beat data
//  d_done     out  1     one-cycle pulse: D burst finished
//  m_valid    out  1     memory beat request valid
//  m_we       out  1     memory beat is write
//  m_addr     out  XLEN  memory beat address
//  m_wdata    out  XLEN  memory write data
//  m_ready    in   1     beat completes when m_valid && m_ready; read data valid on m_rdata this cycle
//  m_rdata    in   XLEN  memory read data
// BEHAVIOUR
//  - Reset: state IDLE, beat counter 0; all outputs 0.
//  - FSM IDLE -> GRANT_D | GRANT_I -> IDLE.
//  - Arbitration in IDLE:
//    - d_req wins over i_req: the older instruction is in MEM.
//    - Exception (anti-starvation): i_req wins if the previous grant was D and i_req was pending during it.
//  - Grant cycle: latch base address, d_we (D only) and owner. Counter = 0.
//    - m_valid rises the cycle after grant, i.e. 1 cycle after req seen in IDLE.
//  - Burst phase:
//    - m_valid=1; m_addr = base + (cnt << $clog2(XLEN/8)); m_we = latched we (0 for I).
//    - m_wdata = d_wdata; d_beat = cnt.
//    - Beat accept (m_valid && m_ready): cnt++.
//    - Reads: owner's rvalid=1 and rdata=m_rdata in the same cycle, combinational pass-through. Non-owner rvalid stays 0.
//    - m_ready low: hold addr/we/wdata unchanged; no counter change.
//  - Last beat (cnt==LINE_WORDS-1) accepted:
//    - Owner's done pulses that same cycle; FSM -> IDLE; cnt wraps to 0.
//    - m_valid drops the next cycle.
//    - Minimum burst time: LINE_WORDS+1 cycles from grant to IDLE (including grant cycle).
//    - The requester drops req in the cycle after done. A new grant is possible the cycle after IDLE is entered.
//  - Lock:
//    - Arbitration only in IDLE. Owner's latched address/we are immune to input changes mid-burst.
//    - Req dropping mid-burst is a protocol error: the burst still completes, no done suppression.
//  - Simultaneous req rise on both sides in IDLE: D granted; I granted right after D done.
//  - Reset mid-burst: abort; next cycle state IDLE, m_valid=0, no done pulse, starvation flag cleared.
//  - Counter: $clog2(LINE_WORDS) bits; address addition wraps modulo 2^XLEN.
// STRUCTURE
//  - Shared package (mem_pkg): typedef enum {MA_IDLE, MA_GRANT_I, MA_GRANT_D} ma_state_t; LINE_WORDS constant; owner_t enum.
//  - One sub-module, burst_counter: counter + last-beat flag + beat-address generator. FSM and muxing stay in the top.
// TESTING
//  - Single I refill, m_ready always 1, i_addr=0x100:
//    - m_addr 0x100,0x104,0x108,0x10C on consecutive cycles.
//    - i_rvalid on each; i_done with the 0x10C beat; m_valid=0 the next cycle.
//  - D writeback d_addr=0x2000, d_we=1, m_ready low on beat 1 for 3 cycles:
//    - m_addr/m_wdata frozen at 0x2004 during the stall; d_beat=1.
//    - Exactly 4 accepted writes, d_done once.
//  - i_req and d_req rise in the same cycle:
//    - D burst first (I outputs all 0 during it).
//    - I burst granted the cycle after D returns to IDLE, even though d_req re-asserts.
//  - d_addr changed mid-burst from 0x40 to 0x80 -> beat addresses stay 0x40..0x4C.
//  - rst asserted on beat 2 of an I burst:
//    - Next cycle m_valid=0, no i_done.
//    - New i_req=0x300 starts a fresh burst from beat 0 at 0x300.
//  - Back-to-back D refills (no I) with LINE_WORDS=8 -> 8 beats each; second grant the cycle after the first burst's IDLE cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D memory-port arbiter.
package mem_pkg;
  localparam int XLEN       = 32;
  localparam int LINE_WORDS = 4;
  localparam int BYTE_SHIFT = $clog2(XLEN / 8);

  typedef enum logic [1:0] {
    MA_IDLE    = 2'd0,
    MA_GRANT_I = 2'd1,
    MA_GRANT_D = 2'd2
  } ma_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Word-granular beat address; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] beat_addr(input logic [XLEN-1:0] base,
                                                input logic [XLEN-1:0] idx);
    return base + (idx << BYTE_SHIFT);
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of I-side, D-side and backing-memory signals around the arbiter.
interface mem_port_arbiter_if import mem_pkg::*; #(
  parameter int LINE_WORDS = mem_pkg::LINE_WORDS
) ();
  localparam int CW = $clog2(LINE_WORDS);

  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic            i_rvalid;
  logic [XLEN-1:0] i_rdata;
  logic            i_done;

  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [CW-1:0]   d_beat;
  logic            d_rvalid;
  logic [XLEN-1:0] d_rdata;
  logic            d_done;

  logic            m_valid;
  logic            m_we;
  logic [XLEN-1:0] m_addr;
  logic [XLEN-1:0] m_wdata;
  logic            m_ready;
  logic [XLEN-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
    output i_rvalid, i_rdata, i_done, d_beat, d_rvalid, d_rdata, d_done,
           m_valid, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
    input  i_rvalid, i_rdata, i_done, d_beat, d_rvalid, d_rdata, d_done,
           m_valid, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_burst_counter.sv
// Beat counter for one burst: index, last-beat flag and beat address.
module burst_counter import mem_pkg::*; #(
  parameter  int LINE_WORDS = mem_pkg::LINE_WORDS,
  localparam int CW         = $clog2(LINE_WORDS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            advance_i,
  input  logic [XLEN-1:0] base_i,
  output logic [CW-1:0]   cnt_o,
  output logic            last_o,
  output logic [XLEN-1:0] addr_o
);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (advance_i) begin
      // LINE_WORDS is a power of two, so the increment wraps to 0 after the last beat.
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CW'(LINE_WORDS - 1));
  assign addr_o = beat_addr(base_i, XLEN'(cnt_q));
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between I-side and D-side line bursts;
// D has priority unless I waited through the previous D burst.
module mem_port_arbiter import mem_pkg::*; #(
  parameter int LINE_WORDS = mem_pkg::LINE_WORDS
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(LINE_WORDS);

  ma_state_t       state_q, state_d;
  owner_t          owner_q, owner_d;
  logic [XLEN-1:0] base_q, base_d;
  logic            we_q, we_d;
  logic            starve_q, starve_d;
  logic            hold_q, hold_d;

  logic            grant_s;
  logic            burst_s;
  logic            accept_s;
  logic            rd_s;
  logic            last_s;
  logic [CW-1:0]   cnt_s;
  logic [XLEN-1:0] addr_s;

  assign burst_s  = (state_q != MA_IDLE);
  assign accept_s = burst_s && bus.m_ready;
  assign rd_s     = accept_s && !we_q;

  burst_counter #(.LINE_WORDS(LINE_WORDS)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (grant_s),
    .advance_i (accept_s),
    .base_i    (base_q),
    .cnt_o     (cnt_s),
    .last_o    (last_s),
    .addr_o    (addr_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MA_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWN_I;
      base_q   <= '0;
      we_q     <= 1'b0;
      starve_q <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      base_q   <= base_d;
      we_q     <= we_d;
      starve_q <= starve_d;
      hold_q   <= hold_d;
    end
  end

  // hold_q masks the IDLE cycle right after done, while the finished requester still shows req.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    base_d   = base_q;
    we_d     = we_q;
    starve_d = starve_q;
    hold_d   = 1'b0;
    grant_s  = 1'b0;
    case (state_q)
      MA_IDLE: begin
        if (!hold_q && (bus.i_req || bus.d_req)) begin
          grant_s  = 1'b1;
          starve_d = 1'b0;
          if (bus.d_req && !(starve_q && bus.i_req)) begin
            state_d = MA_GRANT_D;
            owner_d = OWN_D;
            base_d  = bus.d_addr;
            we_d    = bus.d_we;
          end else begin
            state_d = MA_GRANT_I;
            owner_d = OWN_I;
            base_d  = bus.i_addr;
            we_d    = 1'b0;
          end
        end else begin
          state_d = MA_IDLE;
        end
      end
      MA_GRANT_I: begin
        if (accept_s && last_s) begin
          state_d = MA_IDLE;
          hold_d  = 1'b1;
        end else begin
          state_d = MA_GRANT_I;
        end
      end
      MA_GRANT_D: begin
        starve_d = starve_q || bus.i_req;
        if (accept_s && last_s) begin
          state_d = MA_IDLE;
          hold_d  = 1'b1;
        end else begin
          state_d = MA_GRANT_D;
        end
      end
      default: begin
        state_d = MA_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.m_valid  = 1'b0;
    bus.m_we     = 1'b0;
    bus.m_addr   = '0;
    bus.m_wdata  = '0;
    bus.d_beat   = cnt_s;
    bus.i_rvalid = 1'b0;
    bus.i_rdata  = '0;
    bus.i_done   = 1'b0;
    bus.d_rvalid = 1'b0;
    bus.d_rdata  = '0;
    bus.d_done   = 1'b0;
    if (burst_s) begin
      bus.m_valid = 1'b1;
      bus.m_we    = we_q;
      bus.m_addr  = addr_s;
      bus.m_wdata = bus.d_wdata;
      if (owner_q == OWN_D) begin
        bus.d_rvalid = rd_s;
        bus.d_rdata  = rd_s ? bus.m_rdata : '0;
        bus.d_done   = accept_s && last_s;
      end else begin
        bus.i_rvalid = rd_s;
        bus.i_rdata  = rd_s ? bus.m_rdata : '0;
        bus.i_done   = accept_s && last_s;
      end
    end else begin
      bus.m_valid = 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LINE_WORDS=4 and LINE_WORDS=8 instances.
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.LINE_WORDS(4)) b4 ();
  mem_port_arbiter_if #(.LINE_WORDS(8)) b8 ();

  mem_port_arbiter #(.LINE_WORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  mem_port_arbiter #(.LINE_WORDS(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));

  // Memory returns address ^ KEY; D-side cache supplies a write word tagged by beat index.
  assign b4.m_rdata = b4.m_addr ^ KEY;
  assign b8.m_rdata = b8.m_addr ^ KEY;
  assign b4.d_wdata = 32'hDA7A_0000 | 32'(b4.d_beat);
  assign b8.d_wdata = 32'hDA7A_0000 | 32'(b8.d_beat);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle4(input string tag);
    check({tag, ".m_valid"}, 32'(b4.m_valid), 32'd0);
    check({tag, ".i_done"},  32'(b4.i_done),  32'd0);
    check({tag, ".d_done"},  32'(b4.d_done),  32'd0);
  endtask

  task automatic burst4(input string tag, input bit side_d, input bit we, input logic [31:0] base);
    logic [31:0] a;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      a = base + 32'(k * 4);
      check({tag, ".m_valid"}, 32'(b4.m_valid), 32'd1);
      check({tag, ".m_addr"},  b4.m_addr, a);
      check({tag, ".m_we"},    32'(b4.m_we), 32'(we));
      check({tag, ".d_beat"},  32'(b4.d_beat), 32'(k));
      if (side_d) begin
        check({tag, ".d_rvalid"}, 32'(b4.d_rvalid), 32'(!we));
        check({tag, ".d_rdata"},  b4.d_rdata, we ? 32'd0 : (a ^ KEY));
        check({tag, ".i_rvalid"}, 32'(b4.i_rvalid), 32'd0);
        check({tag, ".i_rdata"},  b4.i_rdata, 32'd0);
        check({tag, ".d_done"},   32'(b4.d_done), 32'(k == 3));
        check({tag, ".i_done"},   32'(b4.i_done), 32'd0);
      end else begin
        check({tag, ".i_rvalid"}, 32'(b4.i_rvalid), 32'd1);
        check({tag, ".i_rdata"},  b4.i_rdata, a ^ KEY);
        check({tag, ".d_rvalid"}, 32'(b4.d_rvalid), 32'd0);
        check({tag, ".d_rdata"},  b4.d_rdata, 32'd0);
        check({tag, ".i_done"},   32'(b4.i_done), 32'(k == 3));
        check({tag, ".d_done"},   32'(b4.d_done), 32'd0);
      end
    end
  endtask

  task automatic burst8(input string tag, input logic [31:0] base);
    logic [31:0] a;
    for (int k = 0; k < 8; k++) begin
      tick();
      #1;
      a = base + 32'(k * 4);
      check({tag, ".m_valid"},  32'(b8.m_valid), 32'd1);
      check({tag, ".m_addr"},   b8.m_addr, a);
      check({tag, ".d_beat"},   32'(b8.d_beat), 32'(k));
      check({tag, ".d_rdata"},  b8.d_rdata, a ^ KEY);
      check({tag, ".d_done"},   32'(b8.d_done), 32'(k == 7));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int rdy [7];
    int idx [7];
    int acc;
    int dn;
    rdy = '{1, 0, 0, 0, 1, 1, 1};
    idx = '{0, 1, 1, 1, 1, 2, 3};

    rst = 1'b1;
    b4.i_req = 1'b0; b4.i_addr = 32'd0; b4.d_req = 1'b0; b4.d_we = 1'b0; b4.d_addr = 32'd0; b4.m_ready = 1'b0;
    b8.i_req = 1'b0; b8.i_addr = 32'd0; b8.d_req = 1'b0; b8.d_we = 1'b0; b8.d_addr = 32'd0; b8.m_ready = 1'b0;

    // Reset state
    tick();
    tick();
    #1;
    chk_idle4("rst");
    check("rst.m_addr", b4.m_addr, 32'd0);
    check("rst.d_beat", 32'(b4.d_beat), 32'd0);
    check("rst.i_rvalid", 32'(b4.i_rvalid), 32'd0);

    // Single I refill at 0x100
    tick();
    rst = 1'b0; b4.m_ready = 1'b1; b4.i_req = 1'b1; b4.i_addr = 32'h100;
    #1;
    chk_idle4("t1.grant");
    burst4("t1", 1'b0, 1'b0, 32'h100);
    tick();
    b4.i_req = 1'b0;
    #1;
    chk_idle4("t1.after");

    // D writeback at 0x2000 with a three-cycle stall on beat 1
    tick();
    b4.d_req = 1'b1; b4.d_we = 1'b1; b4.d_addr = 32'h2000;
    #1;
    chk_idle4("t2.grant");
    acc = 0;
    dn  = 0;
    for (int c = 0; c < 7; c++) begin
      tick();
      b4.m_ready = rdy[c][0];
      #1;
      check("t2.m_addr",  b4.m_addr,  32'h2000 + 32'(idx[c] * 4));
      check("t2.m_wdata", b4.m_wdata, 32'hDA7A_0000 | 32'(idx[c]));
      check("t2.d_beat",  32'(b4.d_beat), 32'(idx[c]));
      check("t2.m_we",    32'(b4.m_we), 32'd1);
      check("t2.d_done",  32'(b4.d_done), 32'(c == 6));
      if (b4.m_valid && b4.m_ready && b4.m_we) acc++;
      if (b4.d_done) dn++;
    end
    check("t2.writes", 32'(acc), 32'd4);
    check("t2.dones",  32'(dn),  32'd1);
    tick();
    b4.d_req = 1'b0; b4.d_we = 1'b0;
    #1;
    chk_idle4("t2.after");

    // Simultaneous requests: D first, then I despite D re-requesting
    tick();
    b4.i_req = 1'b1; b4.i_addr = 32'h500; b4.d_req = 1'b1; b4.d_addr = 32'h600;
    #1;
    chk_idle4("t3.grant");
    burst4("t3.d", 1'b1, 1'b0, 32'h600);
    tick();
    b4.d_req = 1'b0;
    #1;
    chk_idle4("t3.hold");
    tick();
    b4.d_req = 1'b1;
    #1;
    chk_idle4("t3.regrant");
    burst4("t3.i", 1'b0, 1'b0, 32'h500);
    tick();
    b4.i_req = 1'b0;
    #1;
    chk_idle4("t3.hold2");
    tick();
    #1;
    chk_idle4("t3.grant_d2");
    burst4("t3.d2", 1'b1, 1'b0, 32'h600);
    tick();
    b4.d_req = 1'b0;
    #1;
    chk_idle4("t3.after");

    // Address and direction locked mid-burst
    tick();
    b4.d_req = 1'b1; b4.d_addr = 32'h40; b4.d_we = 1'b0;
    #1;
    chk_idle4("t4.grant");
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 2) begin
        b4.d_addr = 32'h80;
        b4.d_we   = 1'b1;
      end
      #1;
      check("t4.m_addr",   b4.m_addr, 32'h40 + 32'(k * 4));
      check("t4.m_we",     32'(b4.m_we), 32'd0);
      check("t4.d_rvalid", 32'(b4.d_rvalid), 32'd1);
      check("t4.d_done",   32'(b4.d_done), 32'(k == 3));
    end
    tick();
    b4.d_req = 1'b0; b4.d_we = 1'b0;
    #1;
    chk_idle4("t4.after");

    // Reset on beat 2 of an I burst, then a fresh burst at 0x300
    tick();
    b4.i_req = 1'b1; b4.i_addr = 32'h200;
    #1;
    chk_idle4("t5.grant");
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 2) rst = 1'b1;
      #1;
      check("t5.m_addr", b4.m_addr, 32'h200 + 32'(k * 4));
      check("t5.i_done", 32'(b4.i_done), 32'd0);
    end
    tick();
    rst = 1'b0; b4.i_addr = 32'h300;
    #1;
    chk_idle4("t5.aborted");
    burst4("t5.fresh", 1'b0, 1'b0, 32'h300);
    tick();
    b4.i_req = 1'b0;
    #1;
    chk_idle4("t5.after");

    // Reset clears the starvation flag: D wins again right after reset
    tick();
    b4.d_req = 1'b1; b4.d_addr = 32'h700;
    #1;
    chk_idle4("t6.grant");
    tick();
    b4.i_req = 1'b1; b4.i_addr = 32'h380;
    #1;
    check("t6.beat0", b4.m_addr, 32'h700);
    tick();
    rst = 1'b1;
    #1;
    check("t6.beat1", b4.m_addr, 32'h704);
    tick();
    rst = 1'b0;
    #1;
    chk_idle4("t6.aborted");
    burst4("t6.d", 1'b1, 1'b0, 32'h700);
    tick();
    b4.d_req = 1'b0;
    #1;
    chk_idle4("t6.hold");
    tick();
    #1;
    chk_idle4("t6.grant_i");
    burst4("t6.i", 1'b0, 1'b0, 32'h380);
    tick();
    b4.i_req = 1'b0;
    #1;
    chk_idle4("t6.after");

    // Back-to-back D refills with LINE_WORDS=8
    tick();
    b8.m_ready = 1'b1; b8.d_req = 1'b1; b8.d_addr = 32'h1000;
    #1;
    check("t7.grant.m_valid", 32'(b8.m_valid), 32'd0);
    burst8("t7.a", 32'h1000);
    tick();
    b8.d_addr = 32'h1800;
    #1;
    check("t7.hold.m_valid", 32'(b8.m_valid), 32'd0);
    tick();
    #1;
    check("t7.regrant.m_valid", 32'(b8.m_valid), 32'd0);
    burst8("t7.b", 32'h1800);
    tick();
    b8.d_req = 1'b0;
    #1;
    check("t7.after.m_valid", 32'(b8.m_valid), 32'd0);
    check("t7.after.d_done",  32'(b8.d_done),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
